// File: rtl/envelope_scheduler_pkg.sv
// EnvelopePkg: voice/frame state encodings, sample width and default envelope steps
// shared by the envelope scheduler and its step unit.
package EnvelopePkg;

    localparam int unsigned SAMPLE_W = 12;
    localparam int unsigned VSTATE_W = 3;

    localparam logic [SAMPLE_W-1:0] LEVEL_MAX        = 12'hFFF;
    localparam logic [SAMPLE_W-1:0] DEF_ATTACK_STEP  = 12'h100;
    localparam logic [SAMPLE_W-1:0] DEF_DECAY_STEP   = 12'h040;
    localparam logic [SAMPLE_W-1:0] DEF_RELEASE_STEP = 12'h020;

    typedef enum logic [VSTATE_W-1:0] {
        V_IDLE    = 3'd0,
        V_ATTACK  = 3'd1,
        V_DECAY   = 3'd2,
        V_SUSTAIN = 3'd3,
        V_RELEASE = 3'd4
    } voiceState_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } frameState_t;

    // Full-precision sample*level, keeping the top SAMPLE_W bits (level is a 0..~1 gain).
    function automatic logic [SAMPLE_W-1:0] scaleSample(input logic [SAMPLE_W-1:0] sample,
                                                        input logic [SAMPLE_W-1:0] level);
        logic [2*SAMPLE_W-1:0] full;
        full = (2*SAMPLE_W)'(sample) * (2*SAMPLE_W)'(level);
        return full[2*SAMPLE_W-1:SAMPLE_W];
    endfunction

endpackage

// File: rtl/envelope_scheduler_step.sv
// EnvelopeStep: combinational ADSR update for one voice plus its enveloped sample.
module EnvelopeStep
    import EnvelopePkg::*;
#(
    parameter logic [SAMPLE_W-1:0] ATTACK_STEP  = DEF_ATTACK_STEP,
    parameter logic [SAMPLE_W-1:0] DECAY_STEP   = DEF_DECAY_STEP,
    parameter logic [SAMPLE_W-1:0] RELEASE_STEP = DEF_RELEASE_STEP
) (
    input  logic [VSTATE_W-1:0] state,
    input  logic [SAMPLE_W-1:0] level,
    input  logic                gate,
    input  logic [SAMPLE_W-1:0] velocity,
    input  logic [SAMPLE_W-1:0] sample,
    output logic [VSTATE_W-1:0] nextState_c,
    output logic [SAMPLE_W-1:0] nextLevel_c,
    output logic [SAMPLE_W-1:0] product_c
);

    voiceState_t         curState;
    voiceState_t         newState;
    logic [SAMPLE_W:0]   attackSum;
    logic [SAMPLE_W:0]   decayDiff;

    always_comb begin
        curState    = voiceState_t'(state);
        newState    = curState;
        nextLevel_c = level;
        attackSum   = {1'b0, level} + {1'b0, ATTACK_STEP};
        decayDiff   = {1'b0, level} - {1'b0, DECAY_STEP};

        case (curState)
            V_IDLE: begin
                if (gate) begin
                    newState    = V_ATTACK;
                    nextLevel_c = '0;
                end
            end
            V_ATTACK: begin
                if (!gate) begin
                    newState = V_RELEASE;
                end else if (attackSum >= {1'b0, LEVEL_MAX}) begin
                    newState    = V_DECAY;
                    nextLevel_c = LEVEL_MAX;
                end else begin
                    nextLevel_c = attackSum[SAMPLE_W-1:0];
                end
            end
            V_DECAY: begin
                // The borrow bit catches a step that would wrap below zero.
                if (!gate) begin
                    newState = V_RELEASE;
                end else if (decayDiff[SAMPLE_W] || (decayDiff[SAMPLE_W-1:0] <= velocity)) begin
                    newState    = V_SUSTAIN;
                    nextLevel_c = velocity;
                end else begin
                    nextLevel_c = decayDiff[SAMPLE_W-1:0];
                end
            end
            V_SUSTAIN: begin
                if (!gate) begin
                    newState = V_RELEASE;
                end else begin
                    nextLevel_c = velocity;
                end
            end
            V_RELEASE: begin
                // Retrigger resumes attack from wherever the release had reached.
                if (gate) begin
                    newState = V_ATTACK;
                end else if (level <= RELEASE_STEP) begin
                    newState    = V_IDLE;
                    nextLevel_c = '0;
                end else begin
                    nextLevel_c = level - RELEASE_STEP;
                end
            end
            default: begin
                newState    = V_IDLE;
                nextLevel_c = '0;
            end
        endcase

        nextState_c = newState;
        product_c   = (newState == V_IDLE) ? '0 : scaleSample(sample, nextLevel_c);
    end

endmodule

// File: rtl/envelope_scheduler.sv
// envelope_scheduler: frame-strobed ADSR envelopes for VOICES voices sharing one step unit,
// mixed into one sample. Define ENVSCHED_SATURATE_EN to clamp the mix instead of averaging.
module envelope_scheduler
    import EnvelopePkg::*;
#(
    parameter int unsigned         VOICES       = 4,
    parameter logic [SAMPLE_W-1:0] ATTACK_STEP  = DEF_ATTACK_STEP,
    parameter logic [SAMPLE_W-1:0] DECAY_STEP   = DEF_DECAY_STEP,
    parameter logic [SAMPLE_W-1:0] RELEASE_STEP = DEF_RELEASE_STEP
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       inSampleReady,
    input  logic [SAMPLE_W*VOICES-1:0] inSample,
    input  logic [VOICES-1:0]          inIsPlaying,
    input  logic [SAMPLE_W*VOICES-1:0] velocity,
    output logic [SAMPLE_W-1:0]        outSample,
    output logic                       outSampleReady,
    output logic                       outBusy,
    output logic [VOICES-1:0]          outVoiceActive,
    output logic                       outOverrun
);

    localparam int unsigned      AVG_SHIFT = $clog2(VOICES);
    localparam int unsigned      ACC_W     = SAMPLE_W + AVG_SHIFT;
    localparam int unsigned      IDX_W     = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(VOICES - 1);

    frameState_t                stateQ;
    frameState_t                stateNext;
    logic [IDX_W-1:0]           voiceIdx;
    logic [ACC_W-1:0]           accum;
    logic [SAMPLE_W*VOICES-1:0] capSample;
    logic [SAMPLE_W*VOICES-1:0] capVelocity;
    logic [VOICES-1:0]          capGate;
    voiceState_t                voiceStateQ [VOICES];
    logic [SAMPLE_W-1:0]        voiceLevelQ [VOICES];

    logic                       acceptFrame;
    logic                       serviceVoice;
    logic                       emitSample;
    logic                       dropStrobe;
    logic                       lastVoice;
    logic [VSTATE_W-1:0]        curVState;
    logic [SAMPLE_W-1:0]        curLevel;
    logic [SAMPLE_W-1:0]        selSample;
    logic [SAMPLE_W-1:0]        selVelocity;
    logic                       selGate;
    logic [VSTATE_W-1:0]        stepState;
    logic [SAMPLE_W-1:0]        stepLevel;
    logic [SAMPLE_W-1:0]        stepProduct;
    logic [SAMPLE_W-1:0]        mixSample;

    assign lastVoice = (voiceIdx == LAST_IDX);

    // Frame state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ <= S_IDLE;
        end else begin
            stateQ <= stateNext;
        end
    end

    // Frame next-state: one voice per cycle in S_RUN, one output cycle in S_DONE.
    always_comb begin
        stateNext = stateQ;
        case (stateQ)
            S_IDLE:  if (inSampleReady) stateNext = S_RUN;
            S_RUN:   if (lastVoice) stateNext = S_DONE;
            S_DONE:  stateNext = inSampleReady ? S_RUN : S_IDLE;
            default: stateNext = S_IDLE;
        endcase
    end

    // Frame control decode; a strobe is only taken while no voice is being serviced.
    always_comb begin
        acceptFrame  = 1'b0;
        serviceVoice = 1'b0;
        emitSample   = 1'b0;
        dropStrobe   = 1'b0;
        case (stateQ)
            S_IDLE: acceptFrame = inSampleReady;
            S_RUN: begin
                serviceVoice = 1'b1;
                dropStrobe   = inSampleReady;
            end
            S_DONE: begin
                emitSample  = 1'b1;
                acceptFrame = inSampleReady;
            end
            default: ;
        endcase
    end

    // Route the voice under service to the shared step unit.
    always_comb begin
        curVState   = voiceStateQ[voiceIdx];
        curLevel    = voiceLevelQ[voiceIdx];
        selSample   = capSample[SAMPLE_W*32'(voiceIdx) +: SAMPLE_W];
        selVelocity = capVelocity[SAMPLE_W*32'(voiceIdx) +: SAMPLE_W];
        selGate     = capGate[voiceIdx];
    end

    EnvelopeStep #(
        .ATTACK_STEP (ATTACK_STEP),
        .DECAY_STEP  (DECAY_STEP),
        .RELEASE_STEP(RELEASE_STEP)
    ) uStep (
        .state      (curVState),
        .level      (curLevel),
        .gate       (selGate),
        .velocity   (selVelocity),
        .sample     (selSample),
        .nextState_c(stepState),
        .nextLevel_c(stepLevel),
        .product_c  (stepProduct)
    );

    always_comb begin
`ifdef ENVSCHED_SATURATE_EN
        mixSample = (accum > ACC_W'(LEVEL_MAX)) ? LEVEL_MAX : accum[SAMPLE_W-1:0];
`else
        mixSample = SAMPLE_W'(accum >> AVG_SHIFT);
`endif
    end

    // Frame capture, mix accumulation and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            voiceIdx       <= '0;
            accum          <= '0;
            capSample      <= '0;
            capVelocity    <= '0;
            capGate        <= '0;
            outSample      <= '0;
            outSampleReady <= 1'b0;
            outBusy        <= 1'b0;
            outVoiceActive <= '0;
            outOverrun     <= 1'b0;
        end else begin
            outSampleReady <= emitSample;
            outBusy        <= (stateNext != S_IDLE);
            if (emitSample) begin
                outSample <= mixSample;
            end
            if (dropStrobe) begin
                outOverrun <= 1'b1;
            end
            if (acceptFrame) begin
                capSample   <= inSample;
                capVelocity <= velocity;
                capGate     <= inIsPlaying;
                voiceIdx    <= '0;
                accum       <= '0;
            end else if (serviceVoice) begin
                accum                    <= accum + ACC_W'(stepProduct);
                outVoiceActive[voiceIdx] <= (stepState != V_IDLE);
                voiceIdx                 <= lastVoice ? '0 : voiceIdx + IDX_W'(1);
            end
        end
    end

    // Per-voice envelope state, written back only for the voice under service.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < VOICES; i++) begin
                voiceStateQ[i] <= V_IDLE;
                voiceLevelQ[i] <= '0;
            end
        end else if (serviceVoice) begin
            voiceStateQ[voiceIdx] <= voiceState_t'(stepState);
            voiceLevelQ[voiceIdx] <= stepLevel;
        end
    end

endmodule

// File: tb/tb_envelope_scheduler.sv
// Scoreboard bench for envelope_scheduler: a frame-level ADSR model predicts each mixed
// sample and its arrival cycle; a monitor pops and compares on every outSampleReady.
module tb_envelope_scheduler;

    localparam int NV  = 4;
    localparam int LAT = NV + 2;
    localparam int ST_IDLE = 0, ST_ATT = 1, ST_DEC = 2, ST_SUS = 3, ST_REL = 4;
`ifdef ENVSCHED_SATURATE_EN
    localparam int ATT_EXP = 'hAFE, SUS_EXP = 'h57F, MIX_EXP = 'hFFF;
`else
    localparam int ATT_EXP = 'h2BF, SUS_EXP = 'h15F, MIX_EXP = 'hAFE;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              inSampleReady = 1'b0;
    logic [12*NV-1:0]  inSample = '0;
    logic [NV-1:0]     inIsPlaying = '0;
    logic [12*NV-1:0]  velocity = '0;
    logic [11:0]       outSample;
    logic              outSampleReady;
    logic              outBusy;
    logic [NV-1:0]     outVoiceActive;
    logic              outOverrun;

    int vectors = 0;
    int miscompares = 0;
    int cycle = 0;
    int expQ[$];
    int cycQ[$];
    int mSt[NV];
    int mLv[NV];

    envelope_scheduler #(.VOICES(NV)) dut (
        .clk           (clk),
        .reset         (reset),
        .inSampleReady (inSampleReady),
        .inSample      (inSample),
        .inIsPlaying   (inIsPlaying),
        .velocity      (velocity),
        .outSample     (outSample),
        .outSampleReady(outSampleReady),
        .outBusy       (outBusy),
        .outVoiceActive(outVoiceActive),
        .outOverrun    (outOverrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NV; i++) begin
            mSt[i] = ST_IDLE;
            mLv[i] = 0;
        end
    endtask

    // One frame of envelope evolution for every voice, returning the expected mix.
    task automatic modelFrame(input logic [12*NV-1:0] smp, input logic [NV-1:0] gate,
                              input logic [12*NV-1:0] vel, output int res);
        int sum = 0;
        for (int i = 0; i < NV; i++) begin
            int v = int'(vel[12*i +: 12]);
            int s = int'(smp[12*i +: 12]);
            case (mSt[i])
                ST_IDLE: if (gate[i]) begin mSt[i] = ST_ATT; mLv[i] = 0; end
                ST_ATT: begin
                    if (!gate[i]) mSt[i] = ST_REL;
                    else begin
                        mLv[i] += 256;
                        if (mLv[i] >= 4095) begin mLv[i] = 4095; mSt[i] = ST_DEC; end
                    end
                end
                ST_DEC: begin
                    if (!gate[i]) mSt[i] = ST_REL;
                    else begin
                        mLv[i] -= 64;
                        if (mLv[i] <= v) begin mLv[i] = v; mSt[i] = ST_SUS; end
                    end
                end
                ST_SUS: begin
                    if (!gate[i]) mSt[i] = ST_REL;
                    else mLv[i] = v;
                end
                default: begin
                    if (gate[i]) mSt[i] = ST_ATT;
                    else if (mLv[i] <= 32) begin mLv[i] = 0; mSt[i] = ST_IDLE; end
                    else mLv[i] -= 32;
                end
            endcase
            if (mSt[i] != ST_IDLE) sum += (s * mLv[i]) >> 12;
        end
`ifdef ENVSCHED_SATURATE_EN
        res = (sum > 4095) ? 4095 : sum;
`else
        res = sum / NV;
`endif
    endtask

    function automatic int modelActive();
        int a = 0;
        for (int i = 0; i < NV; i++) if (mSt[i] != ST_IDLE) a |= (1 << i);
        return a;
    endfunction

    // Raise the strobe now and queue the predicted result.
    task automatic issue(input logic [12*NV-1:0] smp, input logic [NV-1:0] gate,
                         input logic [12*NV-1:0] vel);
        int res;
        inSample = smp;
        inIsPlaying = gate;
        velocity = vel;
        inSampleReady = 1'b1;
        modelFrame(smp, gate, vel, res);
        expQ.push_back(res);
        cycQ.push_back(cycle + LAT);
    endtask

    // Called on a negedge; returns gap cycles later on a negedge.
    task automatic sendFrame(input logic [12*NV-1:0] smp, input logic [NV-1:0] gate,
                             input logic [12*NV-1:0] vel, input int gap);
        issue(smp, gate, vel);
        @(negedge clk);
        inSampleReady = 1'b0;
        repeat (gap - 1) @(negedge clk);
        check("voiceActive", int'(outVoiceActive), modelActive());
        check("busy", int'(outBusy), (gap == 5) ? 1 : 0);
    endtask

    task automatic doReset();
        reset = 1'b1;
        inSampleReady = 1'b0;
        modelReset();
        expQ.delete();
        cycQ.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (expQ.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (expQ.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d expected outputs never arrived", expQ.size());
            expQ.delete();
            cycQ.delete();
        end
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, ".outSample"}, int'(outSample), 0);
        check({tag, ".outSampleReady"}, int'(outSampleReady), 0);
        check({tag, ".outBusy"}, int'(outBusy), 0);
        check({tag, ".outVoiceActive"}, int'(outVoiceActive), 0);
        check({tag, ".outOverrun"}, int'(outOverrun), 0);
    endtask

    // Monitor: every output pulse must match the oldest prediction, value and cycle.
    initial begin
        int e;
        int c;
        forever begin
            @(negedge clk);
            if (outSampleReady) begin
                if (expQ.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpectedReady: got outSampleReady=1, want 0 (cycle %0d)", cycle);
                end else begin
                    e = expQ.pop_front();
                    c = cycQ.pop_front();
                    check("outSample", int'(outSample), e);
                    check("readyCycle", cycle, c);
                end
            end
        end
    end

    initial begin
        logic [12*NV-1:0] smp;
        logic [12*NV-1:0] vel;
        logic [NV-1:0]    gate;

        modelReset();
        repeat (2) @(negedge clk);
        checkAllZero("reset");
        reset = 1'b0;
        @(negedge clk);

        // Single-voice attack, decay, sustain, velocity change, release.
        smp  = 48'h000_000_000_AFF;
        vel  = 48'h000_000_000_800;
        gate = 4'b0001;
        for (int f = 0; f < 17; f++) sendFrame(smp, gate, vel, 10);
        check("attackPeak", int'(outSample), ATT_EXP);
        for (int f = 0; f < 40; f++) sendFrame(smp, gate, vel, 10);
        check("sustain800", int'(outSample), SUS_EXP);
        vel = 48'h000_000_000_600;
        for (int f = 0; f < 3; f++) sendFrame(smp, gate, vel, 10);
        gate = 4'b0000;
        for (int f = 0; f < 50; f++) sendFrame(smp, gate, vel, 10);
        check("releaseIdle", int'(outVoiceActive[0]), 0);
        drain();

        // All voices at full level.
        doReset();
        smp  = {NV{12'hAFF}};
        vel  = {NV{12'hFFF}};
        gate = 4'b1111;
        for (int f = 0; f < 18; f++) sendFrame(smp, gate, vel, 10);
        check("mixFull", int'(outSample), MIX_EXP);
        drain();

        // Randomized gates, velocities, samples and strobe spacing.
        doReset();
        gate = 4'($urandom());
        vel  = 48'({$urandom(), $urandom()});
        for (int f = 0; f < 250; f++) begin
            for (int i = 0; i < NV; i++) begin
                if ($urandom_range(7) == 0) gate[i] = ~gate[i];
                if ($urandom_range(15) == 0) vel[12*i +: 12] = 12'($urandom());
            end
            smp = 48'({$urandom(), $urandom()});
            sendFrame(smp, gate, vel, $urandom_range(12, 5));
        end
        drain();
        check("overrunQuiet", int'(outOverrun), 0);

        // Strobe during S_RUN is dropped; strobe in S_DONE is taken.
        doReset();
        issue(48'({$urandom(), $urandom()}), 4'b1111, {NV{12'h900}});
        @(negedge clk); inSampleReady = 1'b0;
        @(negedge clk); inSampleReady = 1'b1;
        @(negedge clk); inSampleReady = 1'b0;
        @(negedge clk);
        check("busyMidFrame", int'(outBusy), 1);
        @(negedge clk);
        issue(48'({$urandom(), $urandom()}), 4'b0101, {NV{12'h700}});
        @(negedge clk); inSampleReady = 1'b0;
        repeat (8) @(negedge clk);
        check("overrunSet", int'(outOverrun), 1);
        check("handshakeActive", int'(outVoiceActive), modelActive());
        drain();

        // Reset three edges into a frame discards it.
        issue(48'({$urandom(), $urandom()}), 4'b1111, {NV{12'h500}});
        @(negedge clk); inSampleReady = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        modelReset();
        expQ.delete();
        cycQ.delete();
        @(negedge clk);
        checkAllZero("midReset");
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // Strobe coincident with reset is ignored.
        reset = 1'b1;
        inSampleReady = 1'b1;
        inIsPlaying = 4'b1111;
        @(negedge clk);
        reset = 1'b0;
        inSampleReady = 1'b0;
        @(negedge clk);
        check("strobeInReset.busy", int'(outBusy), 0);
        repeat (10) @(negedge clk);
        check("strobeInReset.active", int'(outVoiceActive), 0);

        // Normal operation resumes afterwards.
        for (int f = 0; f < 4; f++) sendFrame(48'({$urandom(), $urandom()}), 4'b1011, {NV{12'hA00}}, 6);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
